zigzag_scan: RTL and testbench

Zig-zag reorder stage for the JPEG entropy path. It accepts quantized 8x8 blocks of Y, Cr and Cb coefficients in raster order, one coefficient per channel per cycle, and buffers each block in a ping-pong memory. It replays each block in JPEG zig-zag order on `enable`-style outputs, feeding the run-length coder directly downstream. The three channels advance in lockstep and share one address sequence.

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/zigzag_scan_if.sv | 29 ++
 rtl/zigzag_bank_ram.sv | 28 ++
 rtl/zigzag_scan.sv | 141 ++++++++++++++
 tb/tb_zigzag_scan.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-path definitions: block size, zig-zag index type,
// bank state encoding and the zig-zag scan table.
package jpeg_pkg;

  localparam int BLK_N = 64;

  typedef logic [5:0] zz_idx_t;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Entry k is the raster address of the k-th coefficient in zig-zag order.
  localparam zz_idx_t ZZ_ORDER [BLK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_scan_if.sv
// Coefficient stream bundle between the quantizer side, the zig-zag stage
// and the run-length coder. master drives raster input and the hold request;
// slave (the zig-zag stage) returns ready and the reordered stream.
interface zigzag_scan_if #(parameter int DW = 10);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] Y_in;
  logic [DW-1:0] Cr_in;
  logic [DW-1:0] Cb_in;
  logic          out_hold;
  logic [DW-1:0] Y_out;
  logic [DW-1:0] Cr_out;
  logic [DW-1:0] Cb_out;
  logic          data_valid;
  logic          block_first;
  logic          block_last;

  modport master (
    output in_valid, Y_in, Cr_in, Cb_in, out_hold,
    input  in_ready, Y_out, Cr_out, Cb_out, data_valid, block_first, block_last
  );

  modport slave (
    input  in_valid, Y_in, Cr_in, Cb_in, out_hold,
    output in_ready, Y_out, Cr_out, Cb_out, data_valid, block_first, block_last
  );

endinterface

// File: rtl/zigzag_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the bank select is the
// address MSB. One synchronous write port, one synchronous read port.
module zigzag_bank_ram #(
  parameter int W  = 30,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AW];

  // Write port: store one packed Y/Cr/Cb triple per accepted coefficient.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered read, held when not enabled so a stalled reader keeps its data.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/zigzag_scan.sv
// Zig-zag reorder stage: raster-order Y/Cr/Cb blocks are written into one of
// two banks and replayed in zig-zag order while the other bank fills.
module zigzag_scan
  import jpeg_pkg::*;
#(
  parameter int DW = 10,
  parameter int N  = BLK_N
) (
  input logic         clk,
  input logic         reset,
  zigzag_scan_if.slave bus
);

  localparam zz_idx_t LAST_IDX = zz_idx_t'(N - 1);

  bank_state_e bank_state     [2];
  bank_state_e bank_state_nxt [2];

  zz_idx_t wc;
  zz_idx_t rc;
  logic    wb;
  logic    rb;

  logic wr_open;
  logic wr_fire;
  logic rd_fire;

  logic rd_v;
  logic rd_first;
  logic rd_last;

  logic [3*DW-1:0] rd_data;

  // Handshake and read-issue decode from the current bank states.
  always_comb begin
    wr_open = (bank_state[wb] == BANK_EMPTY) || (bank_state[wb] == BANK_FILLING);
    wr_fire = bus.in_valid && wr_open;
    // A FULL bank is read in the same cycle it is claimed, so the first
    // zig-zag read overlaps the FULL -> DRAINING step and blocks chain gap-free.
    rd_fire = ((bank_state[rb] == BANK_FULL) || (bank_state[rb] == BANK_DRAINING))
              && !bus.out_hold;
  end

  assign bus.in_ready = wr_open;

  // Bank state next-state: writer and reader never act on the same bank
  // because they only touch disjoint states.
  always_comb begin
    bank_state_nxt[0] = bank_state[0];
    bank_state_nxt[1] = bank_state[1];
    if (wr_fire) begin
      bank_state_nxt[wb] = (wc == LAST_IDX) ? BANK_FULL : BANK_FILLING;
    end
    if (rd_fire) begin
      bank_state_nxt[rb] = (rc == LAST_IDX) ? BANK_EMPTY : BANK_DRAINING;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else begin
      bank_state[0] <= bank_state_nxt[0];
      bank_state[1] <= bank_state_nxt[1];
    end
  end

  // Writer position: raster counter wraps into the other bank after the last coefficient.
  always_ff @(posedge clk) begin
    if (reset) begin
      wc <= '0;
      wb <= 1'b0;
    end else if (wr_fire) begin
      wc <= wc + 6'd1;
      if (wc == LAST_IDX) wb <= ~wb;
    end
  end

  // Reader position: zig-zag counter, frozen by out_hold, hands off to the other bank at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      rc <= '0;
      rb <= 1'b0;
    end else if (rd_fire) begin
      rc <= rc + 6'd1;
      if (rc == LAST_IDX) rb <= ~rb;
    end
  end

  zigzag_bank_ram #(
    .W  (3 * DW),
    .AW (7)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wb, wc}),
    .wr_data ({bus.Y_in, bus.Cr_in, bus.Cb_in}),
    .rd_en   (rd_fire),
    .rd_addr ({rb, ZZ_ORDER[rc]}),
    .rd_data (rd_data)
  );

  // Flags travelling alongside the RAM read; frozen with the RAM data during a hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v     <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
    end else if (!bus.out_hold) begin
      rd_v     <= rd_fire;
      rd_first <= rd_fire && (rc == '0);
      rd_last  <= rd_fire && (rc == LAST_IDX);
    end
  end

  // Output registers: data holds through a pause while the qualifiers drop to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Y_out       <= '0;
      bus.Cr_out      <= '0;
      bus.Cb_out      <= '0;
      bus.data_valid  <= 1'b0;
      bus.block_first <= 1'b0;
      bus.block_last  <= 1'b0;
    end else if (bus.out_hold) begin
      bus.data_valid  <= 1'b0;
      bus.block_first <= 1'b0;
      bus.block_last  <= 1'b0;
    end else begin
      bus.data_valid  <= rd_v;
      bus.block_first <= rd_first;
      bus.block_last  <= rd_last;
      if (rd_v) begin
        {bus.Y_out, bus.Cr_out, bus.Cb_out} <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_scan.sv
// Directed bench for zigzag_scan: single block, input gaps, back-to-back,
// backpressure, reset mid-block and signed extremes.
module tb_zigzag_scan;

  localparam int DW = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  zigzag_scan_if #(.DW(DW)) bus();

  zigzag_scan #(.DW(DW), .N(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int zzTb [64];
  int handZz [16] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5};
  int blkY [64];
  int blkCr [64];
  int blkCb [64];

  int expY [$];
  int expCr [$];
  int expCb [$];
  int outY [$];
  int outCr [$];
  int outCb [$];
  int outCyc [$];
  bit outFirst [$];
  bit outLast [$];

  int lastInCyc;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Output collector, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.data_valid) begin
      outY.push_back($signed(bus.Y_out));
      outCr.push_back($signed(bus.Cr_out));
      outCb.push_back($signed(bus.Cb_out));
      outFirst.push_back(bus.block_first);
      outLast.push_back(bus.block_last);
      outCyc.push_back(cyc);
    end
  end

  // Watchdog so the bench never hangs.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] want);
    total = total + 1;
    assert (obs === want) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Independent zig-zag order built by walking the anti-diagonals.
  task automatic genZigzag();
    int k;
    int lo;
    int hi;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zzTb[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zzTb[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int y, input int cr, input int cb,
                               output int waits, output bit ok);
    bus.in_valid = 1'b1;
    bus.Y_in     = y[DW-1:0];
    bus.Cr_in    = cr[DW-1:0];
    bus.Cb_in    = cb[DW-1:0];
    ok    = 1'b0;
    waits = 0;
    while (!ok && waits < 400) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic sendBlock(input bit gap, output int stalls);
    int w;
    bit ok;
    bit okAll;
    stalls = 0;
    okAll  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(blkY[i], blkCr[i], blkCb[i], w, ok);
      stalls += w;
      okAll = okAll & ok;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
    lastInCyc = cyc;
    if (gap) lastInCyc = lastInCyc - 1;
    checkOutput("block_accepted", okAll, 1);
  endtask

  task automatic expectBlock();
    for (int k = 0; k < 64; k++) begin
      expY.push_back(blkY[zzTb[k]]);
      expCr.push_back(blkCr[zzTb[k]]);
      expCb.push_back(blkCb[zzTb[k]]);
    end
  endtask

  task automatic waitOutputs(input int n);
    int t;
    t = 0;
    while (outY.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic checkContiguous(input string tag);
    int gaps;
    gaps = 0;
    for (int k = 1; k < outCyc.size(); k++) begin
      if (outCyc[k] != outCyc[k-1] + 1) gaps++;
    end
    checkOutput(tag, gaps, 0);
  endtask

  task automatic checkStream(input string tag);
    int n;
    checkOutput({tag, "_count"}, outY.size(), expY.size());
    n = (outY.size() < expY.size()) ? outY.size() : expY.size();
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s_Y[%0d]", tag, k), outY[k], expY[k]);
      checkOutput($sformatf("%s_Cr[%0d]", tag, k), outCr[k], expCr[k]);
      checkOutput($sformatf("%s_Cb[%0d]", tag, k), outCb[k], expCb[k]);
      checkOutput($sformatf("%s_first[%0d]", tag, k), outFirst[k], (k % 64) == 0);
      checkOutput($sformatf("%s_last[%0d]", tag, k), outLast[k], (k % 64) == 63);
    end
    outY.delete(); outCr.delete(); outCb.delete();
    outFirst.delete(); outLast.delete(); outCyc.delete();
    expY.delete(); expCr.delete(); expCb.delete();
  endtask

  initial begin
    int stalls;
    int w;
    bit ok;
    int holdStart;
    int jrHigh;
    int dvHigh;

    genZigzag();
    bus.in_valid = 1'b0;
    bus.Y_in     = '0;
    bus.Cr_in    = '0;
    bus.Cb_in    = '0;
    bus.out_hold = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_data_valid", bus.data_valid, 0);
    checkOutput("rst_Y_out", bus.Y_out, 0);
    checkOutput("rst_first", bus.block_first, 0);
    checkOutput("rst_last", bus.block_last, 0);
    @(posedge clk);
    #1;

    // Single block, continuous input.
    for (int i = 0; i < 64; i++) begin
      blkY[i] = i; blkCr[i] = i + 100; blkCb[i] = -i;
    end
    sendBlock(1'b0, stalls);
    expectBlock();
    waitOutputs(64);
    if (outY.size() >= 64) begin
      checkOutput("single_latency", outCyc[0] - lastInCyc, 2);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("single_hand[%0d]", k), outY[k], handZz[k]);
      checkOutput("single_hand[63]", outY[63], 63);
    end
    checkContiguous("single_contiguous");
    checkStream("single");

    // Same block with in_valid toggling.
    sendBlock(1'b1, stalls);
    expectBlock();
    waitOutputs(64);
    if (outCyc.size() > 0) checkOutput("gap_latency", outCyc[0] - lastInCyc, 2);
    checkStream("gap");

    // Three blocks back-to-back.
    stalls = 0;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) begin
        blkY[i] = i + 64 * b; blkCr[i] = i + 100; blkCb[i] = -i;
      end
      sendBlock(1'b0, w);
      stalls += w;
      expectBlock();
    end
    waitOutputs(192);
    checkOutput("b2b_ready_stalls", stalls, 0);
    checkContiguous("b2b_contiguous");
    checkStream("b2b");

    // Backpressure: hold mid-drain while input keeps streaming.
    for (int i = 0; i < 64; i++) begin
      blkY[i] = i + 300; blkCr[i] = i - 200; blkCb[i] = 5 * i;
    end
    sendBlock(1'b0, stalls);
    expectBlock();
    holdStart = 0;
    for (int i = 0; i < 64; i++) begin
      blkY[i] = i - 300; blkCr[i] = 2 * i; blkCb[i] = -3 * i;
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(blkY[i], blkCr[i], blkCb[i], w, ok);
      if (i == 20) begin
        bus.out_hold = 1'b1;
        holdStart = cyc;
      end
    end
    expectBlock();
    jrHigh = 0;
    dvHigh = 0;
    while (cyc - holdStart < 100) begin
      bus.in_valid = 1'b1;
      bus.Y_in = 10'h155; bus.Cr_in = 10'h0AA; bus.Cb_in = 10'h1FF;
      @(negedge clk);
      if (bus.in_ready) jrHigh++;
      if (bus.data_valid) dvHigh++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_hold = 1'b0;
    checkOutput("bp_ready_during_hold", jrHigh, 0);
    checkOutput("bp_valid_during_hold", dvHigh, 0);
    for (int i = 0; i < 64; i++) begin
      blkY[i] = 100 - i; blkCr[i] = i; blkCb[i] = i - 64;
    end
    sendBlock(1'b0, stalls);
    expectBlock();
    waitOutputs(192);
    checkStream("bp");

    // Reset while block 1 drains and block 2 is at coefficient 40.
    for (int i = 0; i < 64; i++) begin
      blkY[i] = i + 7; blkCr[i] = i + 9; blkCb[i] = i + 11;
    end
    sendBlock(1'b0, stalls);
    for (int i = 0; i < 40; i++) applyStimulus(-i, -i, -i, w, ok);
    bus.in_valid = 1'b1;
    bus.Y_in = 10'd40; bus.Cr_in = 10'd40; bus.Cb_in = 10'd40;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_in_ready", bus.in_ready, 1);
    checkOutput("mid_rst_data_valid", bus.data_valid, 0);
    checkOutput("mid_rst_Y_out", bus.Y_out, 0);
    checkOutput("mid_rst_Cr_out", bus.Cr_out, 0);
    checkOutput("mid_rst_Cb_out", bus.Cb_out, 0);
    checkOutput("mid_rst_first", bus.block_first, 0);
    checkOutput("mid_rst_last", bus.block_last, 0);
    @(posedge clk);
    #1;
    outY.delete(); outCr.delete(); outCb.delete();
    outFirst.delete(); outLast.delete(); outCyc.delete();
    for (int i = 0; i < 64; i++) begin
      blkY[i] = 3 * i - 100; blkCr[i] = 200 - i; blkCb[i] = -2 * i;
    end
    sendBlock(1'b0, stalls);
    expectBlock();
    waitOutputs(64);
    if (outCyc.size() > 0) checkOutput("post_rst_latency", outCyc[0] - lastInCyc, 2);
    checkStream("post_rst");

    // Signed extremes at the DC and last zig-zag positions.
    for (int i = 0; i < 64; i++) begin
      blkY[i] = i - 32; blkCr[i] = i; blkCb[i] = -8 * i;
    end
    blkY[0] = -512; blkY[63] = 511;
    blkCr[0] = 511; blkCr[63] = -512;
    sendBlock(1'b0, stalls);
    expectBlock();
    waitOutputs(64);
    if (outY.size() >= 64) begin
      checkOutput("ext_Y_dc", outY[0], -512);
      checkOutput("ext_first_dc", outFirst[0], 1);
      checkOutput("ext_Y_last", outY[63], 511);
      checkOutput("ext_last_flag", outLast[63], 1);
      checkOutput("ext_Cr_dc", outCr[0], 511);
      checkOutput("ext_Cr_last", outCr[63], -512);
    end
    checkStream("ext");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
